// File: rtl/video_tpg.sv
// Test-pattern AXI-Stream video source: one beat per active pixel, tuser marks pixel (0,0).
// Stands in for the DMA reader during HDMI bring-up and always emits whole frames.
module video_tpg #(
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080,
   parameter int BPP      = 24
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           enable_i,
   input  logic [1:0]     pattern_sel_i,
   input  logic [23:0]    solid_rgb_i,
   output logic           out_axis_tvalid,
   input  logic           out_axis_tready,
   output logic [BPP-1:0] out_axis_tdata,
   output logic           out_axis_tuser,
   output logic [15:0]    frame_cnt_o,
   output logic           busy_o
);

   localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BAR_W = H_ACTIVE / 8;

   localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
   localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t        state, state_nxt;
   logic [XW-1:0] x, x_nxt;
   logic [YW-1:0] y, y_nxt;
   logic [2:0]    bar, bar_nxt;
   logic [XW-1:0] bar_cnt, bar_cnt_nxt;
   logic [1:0]    pat, pat_nxt;
   logic [23:0]   solid, solid_nxt;
   logic          tvalid_nxt, tuser_nxt;
   logic [BPP-1:0] tdata_nxt;
   logic [15:0]   frame_cnt_nxt;

   logic [XW-1:0] x_adv, bar_cnt_adv;
   logic [YW-1:0] y_adv;
   logic [2:0]    bar_adv;
   logic          accept, last_pixel, start_frame;

   // Colour of one pixel; the bar index comes from the running sub-counter so no divider is needed.
   function automatic logic [23:0] pixel_rgb(input logic [1:0]    p,
                                             input logic [23:0]   s,
                                             input logic [XW-1:0] px,
                                             input logic [YW-1:0] py,
                                             input logic [2:0]    b);
      logic [23:0] rgb;
      logic [7:0]  ramp;
      rgb  = 24'h000000;
      ramp = 8'(px);
      case (p)
         2'd0: begin
            case (b)
               3'd0: rgb = 24'hFFFFFF;
               3'd1: rgb = 24'hFFFF00;
               3'd2: rgb = 24'h00FFFF;
               3'd3: rgb = 24'h00FF00;
               3'd4: rgb = 24'hFF00FF;
               3'd5: rgb = 24'hFF0000;
               3'd6: rgb = 24'h0000FF;
               default: rgb = 24'h000000;
            endcase
         end
         2'd1: rgb = {ramp, ramp, ramp};
         2'd2: rgb = (((32'(px) ^ 32'(py)) & 32'h20) != 32'd0) ? 24'hFFFFFF : 24'h000000;
         default: rgb = s;
      endcase
      return rgb;
   endfunction

   assign accept     = out_axis_tvalid && out_axis_tready;
   assign last_pixel = (x == X_LAST) && (y == Y_LAST);
   assign busy_o     = (state == ACTIVE);

   // Coordinates of the pixel following the one currently presented.
   always_comb begin
      x_adv       = x + XW'(1);
      y_adv       = y;
      bar_adv     = bar;
      bar_cnt_adv = bar_cnt + XW'(1);
      if (x == X_LAST) begin
         x_adv       = '0;
         y_adv       = y + YW'(1);
         bar_adv     = 3'd0;
         bar_cnt_adv = '0;
      end else if ((bar_cnt == BAR_LAST) && (bar != 3'd7)) begin
         bar_adv     = bar + 3'd1;
         bar_cnt_adv = '0;
      end
   end

   // Next-state and next output register values; a frame start relatches the pattern inputs.
   always_comb begin
      state_nxt     = state;
      x_nxt         = x;
      y_nxt         = y;
      bar_nxt       = bar;
      bar_cnt_nxt   = bar_cnt;
      pat_nxt       = pat;
      solid_nxt     = solid;
      tvalid_nxt    = out_axis_tvalid;
      tuser_nxt     = out_axis_tuser;
      tdata_nxt     = out_axis_tdata;
      frame_cnt_nxt = frame_cnt_o;
      start_frame   = 1'b0;

      case (state)
         IDLE: begin
            tvalid_nxt = 1'b0;
            tuser_nxt  = 1'b0;
            if (enable_i) begin
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            if (accept) begin
               if (last_pixel) begin
                  frame_cnt_nxt = frame_cnt_o + 16'd1;
                  if (enable_i) begin
                     start_frame = 1'b1;
                  end else begin
                     state_nxt  = IDLE;
                     tvalid_nxt = 1'b0;
                     tuser_nxt  = 1'b0;
                     x_nxt      = '0;
                     y_nxt      = '0;
                  end
               end else begin
                  x_nxt       = x_adv;
                  y_nxt       = y_adv;
                  bar_nxt     = bar_adv;
                  bar_cnt_nxt = bar_cnt_adv;
                  tuser_nxt   = 1'b0;
                  tdata_nxt   = BPP'(pixel_rgb(pat, solid, x_adv, y_adv, bar_adv));
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (start_frame) begin
         state_nxt   = ACTIVE;
         pat_nxt     = pattern_sel_i;
         solid_nxt   = solid_rgb_i;
         x_nxt       = '0;
         y_nxt       = '0;
         bar_nxt     = 3'd0;
         bar_cnt_nxt = '0;
         tvalid_nxt  = 1'b1;
         tuser_nxt   = 1'b1;
         tdata_nxt   = BPP'(pixel_rgb(pattern_sel_i, solid_rgb_i, '0, '0, 3'd0));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= IDLE;
         x               <= '0;
         y               <= '0;
         bar             <= 3'd0;
         bar_cnt         <= '0;
         pat             <= 2'd0;
         solid           <= 24'h000000;
         out_axis_tvalid <= 1'b0;
         out_axis_tuser  <= 1'b0;
         out_axis_tdata  <= '0;
         frame_cnt_o     <= 16'd0;
      end else begin
         state           <= state_nxt;
         x               <= x_nxt;
         y               <= y_nxt;
         bar             <= bar_nxt;
         bar_cnt         <= bar_cnt_nxt;
         pat             <= pat_nxt;
         solid           <= solid_nxt;
         out_axis_tvalid <= tvalid_nxt;
         out_axis_tuser  <= tuser_nxt;
         out_axis_tdata  <= tdata_nxt;
         frame_cnt_o     <= frame_cnt_nxt;
      end
   end

endmodule
